// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Package : i2c_pkg
// Desc    : Shared state encoding and bus-level constants for the I2C slave.
// Rev     : 1.0
// ============================================================================
package i2c_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_WR_BYTE   = 3'd3,
    ST_WR_ACK    = 3'd4,
    ST_RD_BYTE   = 3'd5,
    ST_RD_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } i2c_state_e;

  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  function automatic logic addr_match(input logic [BYTE_W-1:0] addr_byte,
                                      input logic [6:0]        dev_addr);
    return addr_byte[BYTE_W-1:1] == dev_addr;
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_slave_shifter.sv
`default_nettype none
// ============================================================================
// Module  : i2c_slave_shifter
// Desc    : 8-bit MSB-first shift register with bit counter for the I2C slave.
// Rev     : 1.0
// ============================================================================
module i2c_slave_shifter
  import i2c_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              clear,
  input  logic              load,
  input  logic              shift_in,
  input  logic              shift_out,
  input  logic              bit_in,
  input  logic [BYTE_W-1:0] load_data,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              msb_next,
  output logic              last_bit,
  output logic              byte_done
);

  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              done_q, done_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    if (clear) begin
      cnt_d  = 3'd0;
      done_d = 1'b0;
    end else if (load) begin
      shreg_d = load_data;
      cnt_d   = 3'd0;
      done_d  = 1'b0;
    end else if (shift_in) begin
      shreg_d = {shreg_q[BYTE_W-2:0], bit_in};
      cnt_d   = cnt_q + 3'd1;
      done_d  = (cnt_q == 3'd7);
    end else if (shift_out) begin
      shreg_d = {shreg_q[BYTE_W-2:0], 1'b0};
      cnt_d   = cnt_q + 3'd1;
      done_d  = (cnt_q == 3'd7);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shreg_q <= '0;
      cnt_q   <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // rx_byte includes the live bit so the 8th sample is usable in its own cycle
  assign rx_byte   = {shreg_q[BYTE_W-2:0], bit_in};
  assign msb_next  = shreg_d[BYTE_W-1];
  assign last_bit  = (cnt_q == 3'd7);
  assign byte_done = done_q;

endmodule

`default_nettype wire

// File: rtl/i2c_slave_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : i2c_slave_ctrl
// Desc    : I2C slave transaction controller bridging to a register-file port.
// Rev     : 1.0
// ============================================================================
module i2c_slave_ctrl
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         ADDR_W      = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_hist_q, scl_hist_d;
  logic                   sda_hist_q, sda_hist_d;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, sda_rise, sda_fall;
  logic                   start_det, stop_det;

  i2c_state_e             state_q, state_d;
  logic                   sda_oe_q, sda_oe_d;
  logic                   busy_q, busy_d;
  logic [ADDR_W-1:0]      reg_addr_q, reg_addr_d;
  logic [7:0]             reg_wdata_q, reg_wdata_d;
  logic                   reg_we_q, reg_we_d;
  logic                   rw_q, rw_d;
  logic                   first_q, first_d;
  logic                   rd_ack_q, rd_ack_d;

  logic                   sh_clear, sh_load, sh_in, sh_out;
  logic [7:0]             sh_rx_byte;
  logic                   sh_msb_next, sh_last_bit, sh_byte_done;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    scl_hist_d = scl_s;
    sda_hist_d = sda_s;
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s & scl_hist_q;
  assign sda_rise  = sda_s & ~sda_hist_q;
  assign sda_fall  = ~sda_s & sda_hist_q;
  assign start_det = sda_fall & scl_s;
  assign stop_det  = sda_rise & scl_s;

  // Idle bus is high; resetting the sync chain high avoids a false edge
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
    end
  end

  i2c_slave_shifter u_shifter (
    .CLK       (CLK),
    .RST       (RST),
    .clear     (sh_clear),
    .load      (sh_load),
    .shift_in  (sh_in),
    .shift_out (sh_out),
    .bit_in    (sda_s),
    .load_data (reg_rdata),
    .rx_byte   (sh_rx_byte),
    .msb_next  (sh_msb_next),
    .last_bit  (sh_last_bit),
    .byte_done (sh_byte_done)
  );

  always_comb begin
    state_d     = state_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    rw_d        = rw_q;
    first_d     = first_q;
    rd_ack_d    = rd_ack_q;
    sh_clear    = 1'b0;
    sh_load     = 1'b0;
    sh_in       = 1'b0;
    sh_out      = 1'b0;

    // Pointer advances the cycle after each data write strobe
    if (reg_we_q) begin
      reg_addr_d = reg_addr_q + ADDR_W'(1);
    end

    if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      rd_ack_d = 1'b0;
      sh_clear = 1'b1;
    end else if (start_det) begin
      state_d  = ST_ADDR;
      sda_oe_d = 1'b0;
      rd_ack_d = 1'b0;
      sh_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
        end

        ST_ADDR: begin
          if (scl_rise && !sh_byte_done) begin
            sh_in = 1'b1;
            if (sh_last_bit) begin
              if (addr_match(sh_rx_byte, SLAVE_ADDR)) begin
                busy_d = 1'b1;
                rw_d   = sh_rx_byte[0];
              end else begin
                state_d = ST_WAIT_STOP;
                busy_d  = 1'b0;
              end
            end
          end else if (scl_fall && sh_byte_done) begin
            sda_oe_d = ~ACK;
            sh_clear = 1'b1;
            state_d  = ST_ADDR_ACK;
          end
        end

        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q == RW_WRITE) begin
              sda_oe_d = 1'b0;
              first_d  = 1'b1;
              sh_clear = 1'b1;
              state_d  = ST_WR_BYTE;
            end else begin
              sh_load  = 1'b1;
              sda_oe_d = ~sh_msb_next;
              state_d  = ST_RD_BYTE;
            end
          end
        end

        ST_WR_BYTE: begin
          if (scl_rise && !sh_byte_done) begin
            sh_in = 1'b1;
            if (sh_last_bit) begin
              if (first_q) begin
                reg_addr_d = ADDR_W'(sh_rx_byte);
                first_d    = 1'b0;
              end else begin
                reg_wdata_d = sh_rx_byte;
                reg_we_d    = 1'b1;
              end
            end
          end else if (scl_fall && sh_byte_done) begin
            sda_oe_d = ~ACK;
            sh_clear = 1'b1;
            state_d  = ST_WR_ACK;
          end
        end

        ST_WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            sh_clear = 1'b1;
            state_d  = ST_WR_BYTE;
          end
        end

        ST_RD_BYTE: begin
          if (scl_fall) begin
            sh_out = 1'b1;
            if (sh_last_bit) begin
              sda_oe_d = 1'b0;
              rd_ack_d = 1'b0;
              state_d  = ST_RD_ACK;
            end else begin
              sda_oe_d = ~sh_msb_next;
            end
          end
        end

        ST_RD_ACK: begin
          if (scl_rise) begin
            if (sda_s == ACK) begin
              rd_ack_d   = 1'b1;
              reg_addr_d = reg_addr_q + ADDR_W'(1);
            end else begin
              state_d = ST_WAIT_STOP;
              busy_d  = 1'b0;
            end
          end else if (scl_fall && rd_ack_q) begin
            sh_load  = 1'b1;
            sda_oe_d = ~sh_msb_next;
            rd_ack_d = 1'b0;
            state_d  = ST_RD_BYTE;
          end
        end

        ST_WAIT_STOP: begin
          sda_oe_d = 1'b0;
        end

        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= 8'h00;
      reg_we_q    <= 1'b0;
      rw_q        <= RW_WRITE;
      first_q     <= 1'b0;
      rd_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      rw_q        <= rw_d;
      first_q     <= first_d;
      rd_ack_q    <= rd_ack_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_i2c_slave_ctrl
// Desc    : Directed self-checking bench driving an I2C master model.
// Rev     : 1.0
// ============================================================================
module tb_i2c_slave_ctrl;

  localparam int Q = 5;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic [7:0] reg_rdata;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] wr_addr_log[$];
  logic [7:0] wr_data_log[$];
  int         oe_count = 0;

  assign sda_bus   = sda_m & ~sda_oe;
  assign reg_rdata = (reg_addr == 8'h20) ? 8'h81 :
                     (reg_addr == 8'h21) ? 8'h7E : (reg_addr ^ 8'h5A);

  always #5 CLK = ~CLK;

  i2c_slave_ctrl #(.SLAVE_ADDR(7'h50), .ADDR_W(8), .SYNC_STAGES(2)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .scl_in    (scl),
    .sda_in    (sda_bus),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  always @(negedge CLK) begin
    if (reg_we) begin
      wr_addr_log.push_back(reg_addr);
      wr_data_log.push_back(reg_wdata);
    end
    if (sda_oe) oe_count++;
  end

  task automatic wait_q(input int n);
    repeat (n * Q) @(negedge CLK);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl = 1'b1; wait_q(1);
    sda_m = 1'b0; wait_q(1);
    scl = 1'b0; wait_q(1);
  endtask

  task automatic i2c_rep_start();
    sda_m = 1'b1; wait_q(1);
    scl = 1'b1; wait_q(1);
    sda_m = 1'b0; wait_q(1);
    scl = 1'b0; wait_q(1);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q(1);
    scl = 1'b1; wait_q(1);
    sda_m = 1'b1; wait_q(2);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; wait_q(1);
    scl = 1'b1; wait_q(2);
    scl = 1'b0; wait_q(1);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_q(1);
    scl = 1'b1; wait_q(1);
    b = sda_bus; wait_q(1);
    scl = 1'b0; wait_q(1);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack);
  endtask

  task automatic clear_logs();
    wr_addr_log.delete();
    wr_data_log.delete();
    oe_count = 0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe got %b want 0", sda_oe); end
    checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL reset_reg_we got %b want 0", reg_we); end
    checks++; if (reg_wdata !== 8'h00) begin errors++; $display("FAIL reset_reg_wdata got %h want 00", reg_wdata); end
    checks++; if (reg_addr !== 8'h00) begin errors++; $display("FAIL reset_reg_addr got %h want 00", reg_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge CLK); RST = 1'b1;
    wait_q(2);
  endtask

  task automatic test_write();
    logic ack;
    clear_logs();
    i2c_start();
    write_byte(8'hA0, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_addr_ack got %b want 0", ack); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy got %b want 1", busy); end
    write_byte(8'h10, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_ptr_ack got %b want 0", ack); end
    write_byte(8'hA5, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_d0_ack got %b want 0", ack); end
    write_byte(8'h3C, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_d1_ack got %b want 0", ack); end
    i2c_stop();
    checks++;
    if (wr_addr_log.size() != 2) begin
      errors++; $display("FAIL wr_count got %0d want 2", wr_addr_log.size());
    end else begin
      if (wr_addr_log[0] !== 8'h10 || wr_data_log[0] !== 8'hA5) begin
        errors++; $display("FAIL wr_first got %h=%h want 10=a5", wr_addr_log[0], wr_data_log[0]);
      end
      checks++;
      if (wr_addr_log[1] !== 8'h11 || wr_data_log[1] !== 8'h3C) begin
        errors++; $display("FAIL wr_second got %h=%h want 11=3c", wr_addr_log[1], wr_data_log[1]);
      end
    end
    checks++; if (reg_addr !== 8'h12) begin errors++; $display("FAIL wr_ptr_end got %h want 12", reg_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_stop got %b want 0", busy); end
  endtask

  task automatic test_nack();
    logic ack;
    clear_logs();
    i2c_start();
    write_byte(8'hA2, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL nack_addr got %b want 1", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nack_busy got %b want 0", busy); end
    write_byte(8'h55, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL nack_data got %b want 1", ack); end
    i2c_stop();
    checks++; if (wr_addr_log.size() != 0) begin errors++; $display("FAIL nack_writes got %0d want 0", wr_addr_log.size()); end
    checks++; if (oe_count != 0) begin errors++; $display("FAIL nack_sda_driven got %0d cycles want 0", oe_count); end
    checks++; if (reg_addr !== 8'h12) begin errors++; $display("FAIL nack_ptr got %h want 12", reg_addr); end
  endtask

  task automatic test_read();
    logic       ack;
    logic [7:0] d;
    clear_logs();
    i2c_start();
    write_byte(8'hA0, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rd_waddr_ack got %b want 0", ack); end
    write_byte(8'h20, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rd_ptr_ack got %b want 0", ack); end
    i2c_rep_start();
    write_byte(8'hA1, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rd_raddr_ack got %b want 0", ack); end
    read_byte(d, 1'b0);
    checks++; if (d !== 8'h81) begin errors++; $display("FAIL rd_byte0 got %h want 81", d); end
    read_byte(d, 1'b1);
    checks++; if (d !== 8'h7E) begin errors++; $display("FAIL rd_byte1 got %h want 7e", d); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_nack got %b want 0", busy); end
    checks++; if (reg_addr !== 8'h21) begin errors++; $display("FAIL rd_ptr_end got %h want 21", reg_addr); end
    write_byte(8'hFF, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rd_wait_stop_ack got %b want 1", ack); end
    i2c_stop();
    checks++; if (wr_addr_log.size() != 0) begin errors++; $display("FAIL rd_writes got %0d want 0", wr_addr_log.size()); end
  endtask

  task automatic test_wrap();
    logic ack;
    clear_logs();
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'hFF, ack);
    write_byte(8'h11, ack);
    write_byte(8'h22, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wrap_ack got %b want 0", ack); end
    i2c_stop();
    checks++;
    if (wr_addr_log.size() != 2) begin
      errors++; $display("FAIL wrap_count got %0d want 2", wr_addr_log.size());
    end else begin
      if (wr_addr_log[0] !== 8'hFF || wr_data_log[0] !== 8'h11) begin
        errors++; $display("FAIL wrap_first got %h=%h want ff=11", wr_addr_log[0], wr_data_log[0]);
      end
      checks++;
      if (wr_addr_log[1] !== 8'h00 || wr_data_log[1] !== 8'h22) begin
        errors++; $display("FAIL wrap_second got %h=%h want 00=22", wr_addr_log[1], wr_data_log[1]);
      end
    end
    checks++; if (reg_addr !== 8'h01) begin errors++; $display("FAIL wrap_ptr got %h want 01", reg_addr); end
  endtask

  task automatic test_stop_mid();
    logic ack;
    clear_logs();
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h40, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mid_ptr_ack got %b want 0", ack); end
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    i2c_stop();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL mid_sda_oe got %b want 0", sda_oe); end
    checks++; if (wr_addr_log.size() != 0) begin errors++; $display("FAIL mid_writes got %0d want 0", wr_addr_log.size()); end
    checks++; if (reg_addr !== 8'h40) begin errors++; $display("FAIL mid_ptr got %h want 40", reg_addr); end
  endtask

  task automatic test_reset_mid();
    logic ack;
    i2c_start();
    write_byte(8'hA1, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_addr_ack got %b want 0", ack); end
    // pointer 0x40 reads 0x1A: MSB 0, so the slave is pulling SDA low now
    checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL rst_pre_sda_oe got %b want 1", sda_oe); end
    @(negedge CLK); #2 RST = 1'b0;
    #1;
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rst_sda_oe got %b want 0", sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (reg_addr !== 8'h00) begin errors++; $display("FAIL rst_reg_addr got %h want 00", reg_addr); end
    checks++; if (reg_wdata !== 8'h00) begin errors++; $display("FAIL rst_reg_wdata got %h want 00", reg_wdata); end
    checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL rst_reg_we got %b want 0", reg_we); end
    sda_m = 1'b1; scl = 1'b1;
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_write();
    test_nack();
    test_read();
    test_wrap();
    test_stop_mid();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
